load_ab: RTL and testbench

//   Read-side counterpart of the A/B operand save path. Snapshots the 4-bit
//   A and B registers on request and repacks them into the 8-bit data_AB word

---
 rtl/load_ab.sv | 83 ++++++++
 tb/tb_load_ab.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_ab.sv
// Snapshot FIFO for the A/B operand registers: packs {A,B} or {B,A} per pos_save
// and drains words toward the host over a show-ahead valid/ready port.
module load_ab #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pos_save,
   input  logic                       capture,
   input  logic [3:0]                 data_inA,
   input  logic [3:0]                 data_inB,
   input  logic                       clr_ovf,
   output logic [7:0]                 data_AB_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    word;
   logic          pop, push, drop;

   // Handshake: a word transfers on any edge where out_valid & out_ready; while
   // out_valid is high and no transfer occurs, data_AB_out holds its value.
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign out_valid = ~empty;

   assign word = pos_save ? {data_inA, data_inB} : {data_inB, data_inA};
   assign pop  = out_valid & out_ready;
   assign push = capture & (~full | pop);
   assign drop = capture & full & ~pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)         overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: stale entries are unreachable once count is zero.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= word;
   end

   assign data_AB_out = out_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign count       = count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_load_ab.sv
// Randomized and directed bench for load_ab against a queue-based reference.
module tb_load_ab;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, pos_save, capture, clr_ovf, out_ready;
   logic [3:0] data_inA, data_inB;
   logic [7:0] data_AB_out;
   logic       out_valid, full, empty, overflow;
   logic [2:0] count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic       exp_ovf;

   load_ab #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pos_save(pos_save), .capture(capture),
      .data_inA(data_inA), .data_inB(data_inB), .clr_ovf(clr_ovf),
      .data_AB_out(data_AB_out), .out_valid(out_valid), .out_ready(out_ready),
      .full(full), .empty(empty), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] obs_vec();
      return {out_valid, data_AB_out, count, full, empty, overflow};
   endfunction

   function automatic logic [14:0] exp_vec();
      logic [7:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
      return {exp_q.size() > 0, head, 3'(exp_q.size()),
              exp_q.size() == DEPTH, exp_q.size() == 0, exp_ovf};
   endfunction

   task automatic drive(input logic cap, input logic [3:0] a, input logic [3:0] b,
                        input logic pos, input logic rdy, input logic clr);
      capture = cap; data_inA = a; data_inB = b; pos_save = pos;
      out_ready = rdy; clr_ovf = clr;
   endtask

   // Advance one clock and apply the reference rules to the inputs of that cycle.
   task automatic tick();
      logic       m_pop, m_full, m_push;
      logic [7:0] w;
      w      = pos_save ? {data_inA, data_inB} : {data_inB, data_inA};
      m_full = (exp_q.size() == DEPTH);
      m_pop  = (exp_q.size() > 0) && out_ready;
      m_push = capture && (!m_full || m_pop);
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         exp_ovf = 1'b0;
      end else begin
         if (m_pop) void'(exp_q.pop_front());
         if (m_push) exp_q.push_back(w);
         if (capture && m_full && !m_pop) exp_ovf = 1'b1;
         else if (clr_ovf) exp_ovf = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (obs_vec() !== 15'b0_00000000_000_0_1_0) begin
         n_errors++;
         $display("FAIL reset_state: got %b expected %b", obs_vec(), 15'b0_00000000_000_0_1_0);
      end
   endtask

   task automatic test_packing();
      drive(1, 4'h3, 4'hC, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || data_AB_out !== 8'h3C) begin
         n_errors++;
         $display("FAIL pack_pos1: valid=%b data=%h expected valid=1 data=3c", out_valid, data_AB_out);
      end
      drive(0, 0, 0, 0, 1, 0);
      tick();
      drive(1, 4'h3, 4'hC, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || data_AB_out !== 8'hC3) begin
         n_errors++;
         $display("FAIL pack_pos0: valid=%b data=%h expected valid=1 data=c3", out_valid, data_AB_out);
      end
      drive(0, 0, 0, 0, 1, 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_errors++;
         $display("FAIL pack_drained: got %b expected %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_overflow();
      logic [7:0] want;
      for (int i = 1; i <= 4; i++) begin
         drive(1, 4'(i), 4'(i), 1, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_four: full=%b count=%0d ovf=%b expected 1/4/0", full, count, overflow);
      end
      drive(1, 4'h5, 4'h5, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (overflow !== 1'b1 || count !== 3'd4 || data_AB_out !== 8'h11) begin
         n_errors++;
         $display("FAIL drop_fifth: ovf=%b count=%0d head=%h expected 1/4/11", overflow, count, data_AB_out);
      end
      drive(0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         want = {4'(i), 4'(i)};
         n_checks++;
         if (out_valid !== 1'b1 || data_AB_out !== want) begin
            n_errors++;
            $display("FAIL drain_order[%0d]: valid=%b data=%h expected 1/%h", i, out_valid, data_AB_out, want);
         end
         tick();
      end
      n_checks++;
      if (empty !== 1'b1 || overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL drain_empty: empty=%b ovf=%b expected 1/1", empty, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      drive(0, 0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'(i + 6), 4'h0, 0, 0, 0);
         tick();
      end
      drive(1, 4'hE, 4'hD, 1, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (count !== 3'd4 || overflow !== 1'b0 || data_AB_out !== 8'h07) begin
         n_errors++;
         $display("FAIL full_push_pop: count=%0d ovf=%b head=%h expected 4/0/07", count, overflow, data_AB_out);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_errors++;
         $display("FAIL full_push_pop_model: got %b expected %b", obs_vec(), exp_vec());
      end
      drive(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (exp_q.size() != 0 || obs_vec() !== exp_vec()) begin
         n_errors++;
         $display("FAIL full_tail: got %b expected %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      int caps = 0;
      while (caps < 10) begin
         drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         caps++;
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL wrap[%0d]: got %b expected %b", caps, obs_vec(), exp_vec());
         end
      end
      drive(0, 0, 0, 0, 1, 0);
      while (exp_q.size() > 0) begin
         n_checks++;
         if (data_AB_out !== exp_q[0]) begin
            n_errors++;
            $display("FAIL wrap_drain: got %h expected %h", data_AB_out, exp_q[0]);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'(i), 4'hF, 1, 0, 0);
         tick();
      end
      n_checks++;
      if (count !== 3'd3) begin
         n_errors++;
         $display("FAIL pre_reset_count: got %0d expected 3", count);
      end
      rst = 1'b1;
      drive(1, 4'h9, 4'h9, 1, 1, 0);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_vec() !== 15'b0_00000000_000_0_1_0) begin
         n_errors++;
         $display("FAIL mid_reset: got %b expected %b", obs_vec(), 15'b0_00000000_000_0_1_0);
      end
   endtask

   task automatic test_round_trip();
      logic [7:0] w;
      w = 8'hA5;
      // Save path with pos_save=0 unpacks W as B = W[7:4], A = W[3:0].
      drive(1, w[3:0], w[7:4], 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (data_AB_out !== 8'hA5) begin
         n_errors++;
         $display("FAIL round_trip: got %h expected a5", data_AB_out);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'h1, 4'h2, 1, 0, 0);
         tick();
      end
      drive(1, 4'h1, 4'h2, 1, 0, 1);
      tick();
      n_checks++;
      if (overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_with_drop: got %b expected 1", overflow);
      end
      drive(0, 0, 0, 0, 0, 1);
      tick();
      n_checks++;
      if (overflow !== 1'b0 || count !== 3'd4) begin
         n_errors++;
         $display("FAIL clr_ovf: ovf=%b count=%0d expected 0/4", overflow, count);
      end
   endtask

   task automatic test_random();
      logic [14:0] held;
      logic        hold_chk;
      for (int i = 0; i < 400; i++) begin
         hold_chk = out_valid;
         held     = {7'b0, data_AB_out};
         drive(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
         rst = ($urandom_range(0, 99) == 0);
         if (out_ready || rst) hold_chk = 1'b0;
         tick();
         rst = 1'b0;
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL random[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
         end
         if (hold_chk) begin
            n_checks++;
            if (data_AB_out !== held[7:0]) begin
               n_errors++;
               $display("FAIL hold[%0d]: got %h expected %h", i, data_AB_out, held[7:0]);
            end
         end
      end
   endtask

   initial begin
      exp_ovf = 1'b0;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      test_reset();
      test_packing();
      test_overflow();
      do_reset();
      test_full_push_pop();
      test_back_to_back();
      test_round_trip();
      do_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
